// File: rtl/vector_checker_pkg.sv
// rtl/vector_checker_pkg.sv - shared types and defaults for the vector checker
// Purpose: FSM state encoding and default geometry used by vector_checker and its memory.
// Ports: none (package).
package vector_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vc_state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/vector_checker_mem.sv
// rtl/vector_checker_mem.sv - expected-vector storage, one write port, async read
// Purpose: holds the expected words; deliberately not reset so a reset keeps loaded vectors.
// Ports:
//   clk            - write clock
//   we/waddr/wdata - synchronous write port
//   raddr/rdata    - asynchronous (combinational) read port
module vector_checker_mem
  import vector_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vector_checker.sv
// rtl/vector_checker.sv - compares a stream of DUT output words against stored expected vectors
// Purpose: load expected words, then on start compare num_vec qualified DUT words in order
//   and report pass, error count and the first failing index/value.
// Optional feature: define VECTOR_CHECKER_MASK_EN to add a per-slot compare mask (exp_mask).
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   exp_we/exp_addr/exp_data     - expected-vector write (ignored while busy)
//   exp_mask                     - per-slot compare mask (VECTOR_CHECKER_MASK_EN only)
//   num_vec, start               - run length (1..DEPTH) and one-cycle run request
//   dut_valid, dut_out           - word under check
//   busy, done, pass             - run status
//   err_count                    - saturating mismatch count for the run
//   first_err_idx, first_err_got - index and value of the first mismatch
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_addr,
  input  logic [WIDTH-1:0]         exp_data,
`ifdef VECTOR_CHECKER_MASK_EN
  input  logic [WIDTH-1:0]         exp_mask,
`endif
  input  logic [$clog2(DEPTH):0]   num_vec,
  input  logic                     start,
  input  logic                     dut_valid,
  input  logic [WIDTH-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH):0]   err_count,
  output logic [$clog2(DEPTH)-1:0] first_err_idx,
  output logic [WIDTH-1:0]         first_err_got
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef VECTOR_CHECKER_MASK_EN
  localparam int MW = 2 * WIDTH;
`else
  localparam int MW = WIDTH;
`endif

  vc_state_e        state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    num_q, num_d;
  logic [CW-1:0]    err_q, err_d;
  logic [AW-1:0]    first_idx_q, first_idx_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             mem_we;
  logic [MW-1:0]    mem_wdata;
  logic [MW-1:0]    mem_rdata;
  logic [WIDTH-1:0] exp_word;
  logic [WIDTH-1:0] mask_word;
  logic             start_ok;
  logic             mismatch;
  logic             last_cmp;

  // Loading is locked out during a run so the vectors under compare cannot change.
  assign mem_we = exp_we && (state_q != ST_RUN);

`ifdef VECTOR_CHECKER_MASK_EN
  assign mem_wdata = {exp_mask, exp_data};
  assign exp_word  = mem_rdata[WIDTH-1:0];
  assign mask_word = mem_rdata[MW-1:WIDTH];
`else
  assign mem_wdata = exp_data;
  assign exp_word  = mem_rdata;
  assign mask_word = '1;
`endif

  vector_checker_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (exp_addr),
    .wdata (mem_wdata),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

  assign start_ok = start && (num_vec != '0) && (num_vec <= DEPTH_C);
  assign mismatch = ((dut_out ^ exp_word) & mask_word) != '0;
  // num_q is one wider than idx_q so a full DEPTH-long run is representable.
  assign last_cmp = ({1'b0, idx_q} + CW'(1)) == num_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    err_d       = err_q;
    first_idx_d = first_idx_q;
    first_got_d = first_got_q;
    done_d      = done_q;
    pass_d      = pass_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d     = ST_RUN;
          idx_d       = '0;
          num_d       = num_vec;
          err_d       = '0;
          first_idx_d = '0;
          first_got_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (dut_valid) begin
          idx_d = idx_q + AW'(1);
          if (mismatch) begin
            if (err_q == '0) begin
              first_idx_d = idx_q;
              first_got_d = dut_out;
            end
            if (err_q != DEPTH_C) begin
              err_d = err_q + CW'(1);
            end
          end
          if (last_cmp) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_q == '0) && !mismatch;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      err_q       <= '0;
      first_idx_q <= '0;
      first_got_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      err_q       <= err_d;
      first_idx_q <= first_idx_d;
      first_got_q <= first_got_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy          = (state_q == ST_RUN);
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_idx_q;
  assign first_err_got = first_got_q;

endmodule

// File: tb/tb_vector_checker.sv
// tb/tb_vector_checker.sv - scoreboard bench for vector_checker with a behavioural reference model
module tb_vector_checker;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [W-1:0]  exp_data = '0;
  logic [W-1:0]  exp_mask = '1;
  logic [AW:0]   num_vec = '0;
  logic          start = 1'b0;
  logic          dut_valid = 1'b0;
  logic [W-1:0]  dut_out = '0;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_idx;
  logic [W-1:0]  first_err_got;

  vector_checker #(.WIDTH(W), .DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .exp_we        (exp_we),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
`ifdef VECTOR_CHECKER_MASK_EN
    .exp_mask      (exp_mask),
`endif
    .num_vec       (num_vec),
    .start         (start),
    .dut_valid     (dut_valid),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_got (first_err_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pass;
    int         errs;
    int         fidx;
    logic [W-1:0] fgot;
  } res_t;

  res_t         sb_q[$];
  logic [W-1:0] model_exp [D];
  logic [W-1:0] model_mask[D];
  logic [W-1:0] got_arr   [D];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising edge of done must match the oldest expected result.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      chk("done_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        res_t r;
        r = sb_q.pop_front();
        chk("pass", 64'(pass), 64'(r.pass));
        chk("err_count", 64'(err_count), 64'(r.errs));
        if (r.errs != 0) begin
          chk("first_err_idx", 64'(first_err_idx), 64'(r.fidx));
          chk("first_err_got", 64'(first_err_got), 64'(r.fgot));
        end
      end
    end
    done_prev = done;
  end

  task automatic load(input int addr, input logic [W-1:0] data, input logic [W-1:0] mask);
    exp_we = 1'b1;
    exp_addr = AW'(addr);
    exp_data = data;
    exp_mask = mask;
    model_exp[addr] = data;
`ifdef VECTOR_CHECKER_MASK_EN
    model_mask[addr] = mask;
`else
    model_mask[addr] = '1;
`endif
    tick();
    exp_we = 1'b0;
  endtask

  function automatic res_t predict(input int n);
    res_t r;
    r.errs = 0;
    r.fidx = 0;
    r.fgot = '0;
    for (int i = 0; i < n; i++) begin
      if (((got_arr[i] ^ model_exp[i]) & model_mask[i]) != 0) begin
        if (r.errs == 0) begin
          r.fidx = i;
          r.fgot = got_arr[i];
        end
        r.errs++;
      end
    end
    if (r.errs > D) r.errs = D;
    r.pass = (r.errs == 0);
    return r;
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_first_err_idx"}, 64'(first_err_idx), 64'd0);
    chk({tag, "_first_err_got"}, 64'(first_err_got), 64'd0);
  endtask

  // Runs n compares from got_arr; gaps inserts idle cycles carrying ignored starts and
  // ignored writes; abort asserts reset after two compares instead of finishing.
  task automatic do_run(input int n, input bit gaps, input bit abort);
    num_vec = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!abort) sb_q.push_back(predict(n));
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (abort && i == 2) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("abort");
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          dut_valid = 1'b0;
          dut_out = W'($urandom);
          start = 1'($urandom_range(0, 1));
          exp_we = 1'($urandom_range(0, 1));
          exp_addr = AW'($urandom);
          exp_data = W'($urandom);
          exp_mask = W'($urandom);
          tick();
          chk("busy_in_gap", 64'(busy), 64'd1);
        end
        start = 1'b0;
        exp_we = 1'b0;
      end
      dut_valid = 1'b1;
      dut_out = got_arr[i];
      tick();
      dut_valid = 1'b0;
      chk("busy_run", 64'(busy), 64'(i < n - 1));
    end
  endtask

  initial begin
    logic [W-1:0] pat [4];
    res_t last;
    pat[0] = 16'h0000; pat[1] = 16'hFFFF; pat[2] = 16'h1234; pat[3] = 16'hAAAA;
    for (int i = 0; i < D; i++) model_mask[i] = '1;

    tick();
    tick();
    reset = 1'b0;
    check_cleared("reset");

    for (int i = 0; i < 4; i++) load(i, pat[i], '1);

    // All-match run
    for (int i = 0; i < 4; i++) got_arr[i] = pat[i];
    do_run(4, 1'b0, 1'b0);
    tick();

    // Single mismatch at index 2
    got_arr[2] = 16'h1235;
    last = predict(4);
    do_run(4, 1'b0, 1'b0);
    tick();

    // Starts with illegal run length are ignored and results hold
    num_vec = '0; start = 1'b1; tick();
    num_vec = (AW+1)'(D + 1); tick();
    start = 1'b0; tick();
    chk("bad_start_busy", 64'(busy), 64'd0);
    chk("bad_start_done", 64'(done), 64'd1);
    chk("bad_start_pass", 64'(pass), 64'(last.pass));
    chk("bad_start_err", 64'(err_count), 64'(last.errs));

    // Gaps plus ignored mid-run starts and writes
    got_arr[2] = pat[2];
    do_run(4, 1'b1, 1'b0);
    tick();

    // Reset mid-run, then memory must still hold the old vectors
    do_run(4, 1'b0, 1'b1);
    do_run(4, 1'b0, 1'b0);
    tick();

    // Saturation: every compare of a full-depth run mismatches
    for (int i = 0; i < D; i++) load(i, W'($urandom), '1);
    for (int i = 0; i < D; i++) got_arr[i] = ~model_exp[i];
    do_run(D, 1'b0, 1'b0);
    tick();

`ifdef VECTOR_CHECKER_MASK_EN
    load(0, 16'h0034, 16'h00FF);
    got_arr[0] = 16'h1234;
    do_run(1, 1'b0, 1'b0);
    tick();
`endif

    // Randomised runs against the reference model
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(1, D);
      for (int k = 0; k < 4; k++) load($urandom_range(0, D - 1), W'($urandom), W'($urandom));
      for (int i = 0; i < n; i++) begin
        got_arr[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : model_exp[i];
      end
      do_run(n, 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
